// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared phase indices, opcodes and default widths for the fetch stage
package fetch_unit_pkg;

   // One-hot phase word bit positions
   localparam int PH_F = 0;
   localparam int PH_R = 1;
   localparam int PH_X = 2;
   localparam int PH_M = 3;
   localparam int PH_W = 4;

   localparam int PC_W_DEF = 16;
   localparam int IR_W_DEF = 16;

   // Opcode field is ir[IR_W-1:IR_W-4]
   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_ALU = 4'h1,
      OP_LD  = 4'h2,
      OP_ST  = 4'h3,
      OP_BR  = 4'h4,
      OP_JAL = 4'h5,
      OP_HLT = 4'hF
   } opcode_e;

   localparam logic [3:0] HLT_OP_DEF = OP_HLT;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory bus between fetch stage and imem
interface fetch_unit_if #(
   parameter int PC_W = 16,
   parameter int IR_W = 16
);
   logic [PC_W-1:0] imem_addr;
   logic [IR_W-1:0] imem_rdata;

   // Fetch stage drives the address, memory returns the word in the same cycle
   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_instr_cnt.sv
// rtl/fetch_instr_cnt.sv - saturating retired-instruction counter with enable
module fetch_instr_cnt #(
   parameter int          CNT_W     = 32,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   // Count enabled cycles, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         cnt <= RESET_VAL[CNT_W-1:0];
      else if (en && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR fetch stage with halt decode; optional counter under FETCH_INSTR_CNT_EN
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              IR_W     = IR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [3:0]      HLT_OP   = HLT_OP_DEF
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [4:0]        phase,
   fetch_unit_if.master      imem,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_target,
   output logic [IR_W-1:0]   ir,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   pc_inc,
   output logic              hlt,
   output logic              halted
`ifdef FETCH_INSTR_CNT_EN
   ,
   output logic [31:0]       instr_cnt
`endif
);

   logic is_hlt_op;

   assign is_hlt_op      = (ir[IR_W-1 -: 4] == HLT_OP);
   assign hlt            = phase[PH_W] & is_hlt_op;
   assign pc_inc         = pc + {{(PC_W-1){1'b0}}, 1'b1};
   assign imem.imem_addr = pc;

   // PC advances at the end of W; a halt parks it on the halt address
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         pc <= RESET_PC;
      else if (phase[PH_W] && !is_hlt_op)
         pc <= br_taken ? br_target : pc_inc;
   end

   // Instruction is captured at the end of F and held for the rest of the cycle
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         ir <= '0;
      else if (phase[PH_F])
         ir <= imem.imem_rdata;
   end

   // Halt status is sticky until reset so software can observe it after the phases stop
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         halted <= 1'b0;
      else if (hlt)
         halted <= 1'b1;
   end

`ifdef FETCH_INSTR_CNT_EN
   fetch_instr_cnt #(
      .CNT_W     (32),
      .RESET_VAL (32'h0)
   ) u_instr_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (phase[PH_W]),
      .cnt   (instr_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [4:0]  phase;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] ir, pc, pc_inc;
   logic        hlt, halted;
   logic [15:0] w_ir, w_pc, w_pc_inc;
   logic        w_hlt, w_halted;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.PC_W(16), .IR_W(16)) imem_bus ();
   fetch_unit_if #(.PC_W(16), .IR_W(16)) wrap_bus ();

   logic [15:0] rdata;
   assign imem_bus.imem_rdata = rdata;
   assign wrap_bus.imem_rdata = rdata;

`ifdef FETCH_INSTR_CNT_EN
   logic [31:0] instr_cnt, w_instr_cnt, sat_cnt;
   logic        sat_en;
`endif

   fetch_unit #(.PC_W(16), .IR_W(16), .RESET_PC(16'h0000), .HLT_OP(4'hF)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .phase     (phase),
      .imem      (imem_bus),
      .br_taken  (br_taken),
      .br_target (br_target),
      .ir        (ir),
      .pc        (pc),
      .pc_inc    (pc_inc),
      .hlt       (hlt),
      .halted    (halted)
`ifdef FETCH_INSTR_CNT_EN
      ,
      .instr_cnt (instr_cnt)
`endif
   );

   fetch_unit #(.PC_W(16), .IR_W(16), .RESET_PC(16'hFFFF), .HLT_OP(4'hF)) u_wrap (
      .clk       (clk),
      .n_rst     (n_rst),
      .phase     (phase),
      .imem      (wrap_bus),
      .br_taken  (br_taken),
      .br_target (br_target),
      .ir        (w_ir),
      .pc        (w_pc),
      .pc_inc    (w_pc_inc),
      .hlt       (w_hlt),
      .halted    (w_halted)
`ifdef FETCH_INSTR_CNT_EN
      ,
      .instr_cnt (w_instr_cnt)
`endif
   );

`ifdef FETCH_INSTR_CNT_EN
   fetch_instr_cnt #(.CNT_W(32), .RESET_VAL(32'hFFFF_FFFE)) u_sat (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (sat_en),
      .cnt   (sat_cnt)
   );
`endif

   typedef struct {
      logic [4:0]  ph;
      logic [15:0] rd;
      logic        bt;
      logic [15:0] tg;
      logic        e_hlt;
      logic [15:0] e_pc;
      logic [15:0] e_ir;
      logic        e_halted;
   } vec_t;

   localparam logic [4:0] P_I = 5'b00000;
   localparam logic [4:0] P_F = 5'b00001;
   localparam logic [4:0] P_R = 5'b00010;
   localparam logic [4:0] P_X = 5'b00100;
   localparam logic [4:0] P_M = 5'b01000;
   localparam logic [4:0] P_W = 5'b10000;

   vec_t vecs[20];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [4:0] ph, input logic [15:0] rd, input logic bt,
                                input logic [15:0] tg, input logic e_hlt, input logic [15:0] e_pc,
                                input logic [15:0] e_ir, input logic e_halted);
      vec_t v;
      v.ph = ph; v.rd = rd; v.bt = bt; v.tg = tg;
      v.e_hlt = e_hlt; v.e_pc = e_pc; v.e_ir = e_ir; v.e_halted = e_halted;
      return v;
   endfunction

   task automatic drive(input logic [4:0] ph, input logic [15:0] rd, input logic bt, input logic [15:0] tg);
      phase = ph; rdata = rd; br_taken = bt; br_target = tg;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] cur_pc;

   initial begin
      n_rst = 1'b0;
      phase = P_I; rdata = '0; br_taken = 1'b0; br_target = '0;
`ifdef FETCH_INSTR_CNT_EN
      sat_en = 1'b0;
`endif

      vecs[0]  = mkv(P_F, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0);
      vecs[1]  = mkv(P_R, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0);
      vecs[2]  = mkv(P_X, 16'hAAAA, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h1234, 1'b0);
      vecs[3]  = mkv(P_M, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0);
      vecs[4]  = mkv(P_W, 16'hAAAA, 1'b0, 16'h0040, 1'b0, 16'h0001, 16'h1234, 1'b0);
      vecs[5]  = mkv(P_F, 16'h2000, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h2000, 1'b0);
      vecs[6]  = mkv(P_R, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h2000, 1'b0);
      vecs[7]  = mkv(P_X, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h2000, 1'b0);
      vecs[8]  = mkv(P_M, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'h2000, 1'b0);
      vecs[9]  = mkv(P_W, 16'h5555, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'h2000, 1'b0);
      vecs[10] = mkv(P_F, 16'h3ABC, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'h3ABC, 1'b0);
      vecs[11] = mkv(P_R, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'h3ABC, 1'b0);
      vecs[12] = mkv(P_X, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'h3ABC, 1'b0);
      vecs[13] = mkv(P_M, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'h3ABC, 1'b0);
      vecs[14] = mkv(P_W, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0005, 16'h3ABC, 1'b0);
      vecs[15] = mkv(P_F, 16'hF000, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'hF000, 1'b0);
      vecs[16] = mkv(P_R, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'hF000, 1'b0);
      vecs[17] = mkv(P_X, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'hF000, 1'b0);
      vecs[18] = mkv(P_M, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'hF000, 1'b0);
      vecs[19] = mkv(P_W, 16'h1111, 1'b1, 16'h0099, 1'b1, 16'h0005, 16'hF000, 1'b1);

      // Reset state
      #12;
      check("rst_pc", {16'h0, pc}, 32'h0);
      check("rst_ir", {16'h0, ir}, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      check("rst_hlt", {31'h0, hlt}, 32'h0);
      check("rst_pc_inc", {16'h0, pc_inc}, 32'h1);
      check("rst_imem_addr", {16'h0, imem_bus.imem_addr}, 32'h0);
      check("rst_wrap_pc", {16'h0, w_pc}, 32'h0000_FFFF);
      check("rst_wrap_pc_inc", {16'h0, w_pc_inc}, 32'h0);
`ifdef FETCH_INSTR_CNT_EN
      check("rst_instr_cnt", instr_cnt, 32'h0);
      check("rst_sat_cnt", sat_cnt, 32'hFFFF_FFFE);
`endif
      @(negedge clk);
      n_rst = 1'b1;
      tick();

      // Table-driven main sequence: three instructions then a halt at pc=5
      cur_pc = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].ph, vecs[i].rd, vecs[i].bt, vecs[i].tg);
         check($sformatf("v%0d_hlt", i), {31'h0, hlt}, {31'h0, vecs[i].e_hlt});
         check($sformatf("v%0d_imem_addr", i), {16'h0, imem_bus.imem_addr}, {16'h0, cur_pc});
         check($sformatf("v%0d_pc_inc", i), {16'h0, pc_inc}, {16'h0, cur_pc + 16'h1});
         tick();
         check($sformatf("v%0d_pc", i), {16'h0, pc}, {16'h0, vecs[i].e_pc});
         check($sformatf("v%0d_ir", i), {16'h0, ir}, {16'h0, vecs[i].e_ir});
         check($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].e_halted});
         if (i == 4) begin
            check("wrap_pc", {16'h0, w_pc}, 32'h0);
            check("wrap_pc_inc", {16'h0, w_pc_inc}, 32'h1);
         end
         cur_pc = vecs[i].e_pc;
      end
`ifdef FETCH_INSTR_CNT_EN
      check("instr_cnt_after_halt", instr_cnt, 32'd4);
`endif

      // Idle after halt: everything holds for 20 cycles
      for (int c = 0; c < 20; c++) begin
         drive(P_I, 16'h7777, 1'b1, 16'h0123);
         check("idle_hlt", {31'h0, hlt}, 32'h0);
         tick();
         check("idle_pc", {16'h0, pc}, 32'h5);
         check("idle_ir", {16'h0, ir}, 32'hF000);
         check("idle_halted", {31'h0, halted}, 32'h1);
      end

      // Restart without reset: fetch resumes from held pc, halted stays set
      drive(P_F, 16'h0000, 1'b0, 16'h0000);
      check("resume_imem_addr", {16'h0, imem_bus.imem_addr}, 32'h5);
      tick();
      check("resume_ir", {16'h0, ir}, 32'h0);
      check("resume_halted", {31'h0, halted}, 32'h1);
      drive(P_R, 16'h0000, 1'b0, 16'h0000); tick();
      drive(P_X, 16'h0000, 1'b0, 16'h0000); tick();
      drive(P_M, 16'h0000, 1'b0, 16'h0000); tick();
      drive(P_W, 16'h0000, 1'b1, 16'h0007);
      check("resume_w_hlt", {31'h0, hlt}, 32'h0);
      tick();
      check("resume_pc", {16'h0, pc}, 32'h7);

      // Asynchronous reset in the middle of X with pc=7
      drive(P_F, 16'h1234, 1'b0, 16'h0000); tick();
      check("pre_rst_ir", {16'h0, ir}, 32'h1234);
      drive(P_R, 16'h0000, 1'b0, 16'h0000); tick();
      drive(P_X, 16'h0000, 1'b0, 16'h0000);
      #2;
      n_rst = 1'b0;
      #1;
      check("async_rst_pc", {16'h0, pc}, 32'h0);
      check("async_rst_ir", {16'h0, ir}, 32'h0);
      check("async_rst_halted", {31'h0, halted}, 32'h0);
`ifdef FETCH_INSTR_CNT_EN
      check("async_rst_instr_cnt", instr_cnt, 32'h0);
`endif
      phase = P_I;
      @(negedge clk);
      n_rst = 1'b1;
      tick();

`ifdef FETCH_INSTR_CNT_EN
      // Saturation: preloaded FFFF_FFFE plus two enabled cycles
      check("sat_start", sat_cnt, 32'hFFFF_FFFE);
      sat_en = 1'b1;
      tick();
      check("sat_first", sat_cnt, 32'hFFFF_FFFF);
      tick();
      check("sat_hold", sat_cnt, 32'hFFFF_FFFF);
      sat_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch and program-counter stage of the multi-cycle CPU. Consumes the one-hot five-phase word (F, R, X, M, W) from the phase generator. Owns the PC and instruction register (IR): it drives the instruction-memory address, captures the instruction at the end of F, and advances the PC at the end of W. It also decodes the halt opcode and returns the `hlt` pulse to the phase generator.

## Interface
- `PC_W`, 16, PC and instruction-memory address width
- `IR_W`, 16, instruction width
- `RESET_PC`, 0, PC value after reset
- `HLT_OP`, 4'hF, opcode in `ir[IR_W-1:IR_W-4]` that halts the core

- `clk` in 1: single clock, all state on rising edge
- `n_rst` in 1: reset, asynchronous, active-low
- `phase` in 5: one-hot phase, bit 0 = F, 1 = R, 2 = X, 3 = M, 4 = W; all-zero = idle
- `imem_addr` out PC_W: instruction address, equal to `pc`
- `imem_rdata` in IR_W: instruction word, asynchronous-read memory, valid same cycle
- `br_taken` in 1: branch/jump taken, sampled only while `phase[4]`
- `br_target` in PC_W: branch destination, sampled with `br_taken`
- `ir` out IR_W: current instruction, registered
- `pc` out PC_W: current PC, registered
- `pc_inc` out PC_W: `pc + 1` mod 2^PC_W, combinational, used for link values
- `hlt` out 1: halt request, combinational
- `halted` out 1: sticky halt status, registered
- `instr_cnt` out 32: retired-instruction count, present only with `FETCH_INSTR_CNT_EN`

## Operation
- Reset (`n_rst` = 0, immediate): `pc` = RESET_PC, `ir` = 0, `halted` = 0, `instr_cnt` = 0. Reset mid-phase discards all in-flight state.
- **F** (`phase[0]`): `ir` <= `imem_rdata` on the closing edge. `pc` is unchanged.
- **R, X, M**: `pc` and `ir` hold.
- **W** (`phase[4]`), non-halt instruction:
  - `pc` <= `br_target` if `br_taken`, else `pc_inc`.
  - PC increment wraps, so all-ones goes to 0.
- **W**, halt instruction (opcode == HLT_OP):
  - `hlt` = 1 for that one cycle.
  - `pc` holds at the halt address and `br_taken` is ignored.
  - `halted` <= 1.
- `hlt` = `phase[4] & (ir[IR_W-1:IR_W-4] == HLT_OP)`. It is never asserted outside W.
- Idle (phase all-zero, after halt or before start): all registers hold and `hlt` = 0.
- `halted` clears only on reset. If phases restart without reset, fetch resumes from the held `pc`.
- F and W are never simultaneous under a legal phase word. If both bits are set, each action is still performed independently (IR capture and PC update on the same edge).

## Timing
- Instruction latency: F edge to valid `ir` is 1 cycle. `ir` is stable through R, X, M and W.
- PC update is visible from the first cycle after W, i.e. the next F.
- `imem_addr` changes only on the W→F edge or on reset, and is stable for the whole of F.
- `hlt` path: combinational from registered `ir` and `phase` to the phase generator. The phase word reads zero on the cycle after W.
- One instruction per 5 cycles. There are no stalls.

## Configuration
- `FETCH_INSTR_CNT_EN`
  - Defined: 32-bit `instr_cnt` port and counter exist. The counter increments on every W cycle, halt instruction included, and saturates at 32'hFFFF_FFFF.
  - Undefined: neither the port nor the counter logic exists. All other behaviour is identical.

## Structure
- Shared package/include:
  - phase bit indices (F=0, R=1, X=2, M=3, W=4)
  - `HLT_OP` and the other opcode constants
  - default `PC_W`/`IR_W`
- Sub-module `fetch_instr_cnt`: saturating counter with enable and async reset, instantiated only under `FETCH_INSTR_CNT_EN`.

## Test plan
- Reset release, `imem_rdata`=16'h1234 during F: `ir`=16'h1234 after the F edge; `pc` 0→1 after W; `imem_addr`=1 at the next F.
- `br_taken`=1, `br_target`=16'h0040 in W: `pc`=16'h0040 at the next F. `br_taken`=1 during X only: `pc` increments normally.
- PC wrap with RESET_PC=16'hFFFF: after one instruction `pc`=0 and `pc_inc`=1.
- Halt instruction 16'hF000 fetched at pc=5:
  - `hlt`=1 for exactly the W cycle, `pc` stays 5, `halted`=1.
  - With phase held at 0 for 20 cycles, `pc`, `ir` and `halted` do not change.
- `n_rst` low mid-X with `pc`=7: `pc`=0, `ir`=0 and `halted`=0 immediately, with no clock edge needed.
- With `FETCH_INSTR_CNT_EN`: 3 instructions then halt gives `instr_cnt`=4. With the counter preloaded to 32'hFFFF_FFFE, two more W cycles leave it at 32'hFFFF_FFFF.
